// File: rtl/sram_layer_addr_gen_if.sv
// Bundles the layer request, config and SRAM-side handshake signals of
// sram_layer_addr_gen; the slave modport is the generator's view.
interface sram_layer_addr_gen_if #(
    parameter int NUM_LAYERS = 4,
    parameter int PIX_IDX_W  = 21,
    parameter int ADDR_W     = 20,
    parameter int PPW_LOG2   = 2
);
    localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int SUB_W   = (PPW_LOG2 > 0) ? PPW_LOG2 : 1;

    logic                            i_cfg_we;
    logic [LAYER_W-1:0]              i_cfg_layer;
    logic [ADDR_W-1:0]               i_cfg_base;
    logic [ADDR_W-1:0]               i_cfg_limit;
    logic [NUM_LAYERS-1:0]           i_req_valid;
    logic [NUM_LAYERS*PIX_IDX_W-1:0] i_req_pix_idx;
    logic [NUM_LAYERS-1:0]           o_req_ready;
    logic                            o_sram_valid;
    logic                            i_sram_ready;
    logic [ADDR_W-1:0]               o_sram_addr;
    logic [SUB_W-1:0]                o_sub_idx;
    logic [LAYER_W-1:0]              o_layer;
    logic                            o_oob;

    modport slave (
        input  i_cfg_we, i_cfg_layer, i_cfg_base, i_cfg_limit,
        input  i_req_valid, i_req_pix_idx, i_sram_ready,
        output o_req_ready, o_sram_valid, o_sram_addr, o_sub_idx, o_layer, o_oob
    );

    modport master (
        output i_cfg_we, i_cfg_layer, i_cfg_base, i_cfg_limit,
        output i_req_valid, i_req_pix_idx, i_sram_ready,
        input  o_req_ready, o_sram_valid, o_sram_addr, o_sub_idx, o_layer, o_oob
    );
endinterface

// File: rtl/sram_layer_addr_gen.sv
// Round-robin layer arbiter feeding a two-register pipeline that turns a pixel
// index into a packed SRAM word address with bounds checking against per-layer limits.
module sram_layer_addr_gen #(
    parameter int NUM_LAYERS = 4,
    parameter int PIX_IDX_W  = 21,
    parameter int ADDR_W     = 20,
    parameter int PPW_LOG2   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    sram_layer_addr_gen_if.slave bus
);
    localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int SUB_W   = (PPW_LOG2 > 0) ? PPW_LOG2 : 1;
    localparam int EXT_W   = (PIX_IDX_W > ADDR_W) ? PIX_IDX_W : ADDR_W;

    logic [ADDR_W-1:0]    base_q  [NUM_LAYERS];
    logic [ADDR_W-1:0]    base_d  [NUM_LAYERS];
    logic [ADDR_W-1:0]    limit_q [NUM_LAYERS];
    logic [ADDR_W-1:0]    limit_d [NUM_LAYERS];
    logic [LAYER_W-1:0]   last_grant_q, last_grant_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [PIX_IDX_W-1:0] s1_idx_q, s1_idx_d;
    logic [LAYER_W-1:0]   s1_layer_q, s1_layer_d;
    logic                 sram_valid_q, sram_valid_d;
    logic [ADDR_W-1:0]    sram_addr_q, sram_addr_d;
    logic [SUB_W-1:0]     sub_idx_q, sub_idx_d;
    logic [LAYER_W-1:0]   layer_q, layer_d;
    logic                 oob_q, oob_d;

    logic                 s2_adv, s1_adv, grant_any, accept;
    logic [LAYER_W-1:0]   grant_sel;
    int                   cand;
    logic [PIX_IDX_W-1:0] req_idx_sel;
    logic [EXT_W-1:0]     offset_ext;
    logic [ADDR_W-1:0]    offset_lo, s2_base, s2_limit;
    logic                 offset_hi_nz, s2_oob;
    logic [SUB_W-1:0]     s2_sub;

    assign s2_adv = !sram_valid_q || bus.i_sram_ready;
    assign s1_adv = !s1_valid_q || s2_adv;
    assign accept = grant_any && s1_adv && i_rst_n;

    // Rotating priority: first requester found searching upward from last_grant+1.
    always_comb begin
        grant_any = 1'b0;
        grant_sel = '0;
        cand      = 0;
        for (int i = 1; i <= NUM_LAYERS; i++) begin
            cand = (int'(last_grant_q) + i) % NUM_LAYERS;
            for (int k = 0; k < NUM_LAYERS; k++) begin
                if (!grant_any && (cand == k) && bus.i_req_valid[k]) begin
                    grant_any = 1'b1;
                    grant_sel = LAYER_W'(k);
                end
            end
        end
    end

    always_comb begin
        req_idx_sel = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (grant_sel == LAYER_W'(k)) begin
                req_idx_sel = bus.i_req_pix_idx[k*PIX_IDX_W +: PIX_IDX_W];
            end
        end
    end

    always_comb begin
        base_d  = base_q;
        limit_d = limit_q;
        if (bus.i_cfg_we && (int'(bus.i_cfg_layer) < NUM_LAYERS)) begin
            base_d[bus.i_cfg_layer]  = bus.i_cfg_base;
            limit_d[bus.i_cfg_layer] = bus.i_cfg_limit;
        end
    end

    // Offset bits above ADDR_W can never fit the address space, so they force OOB.
    always_comb begin
        s2_base      = base_q[s1_layer_q];
        s2_limit     = limit_q[s1_layer_q];
        offset_ext   = EXT_W'(s1_idx_q) >> PPW_LOG2;
        offset_hi_nz = (offset_ext >> ADDR_W) != '0;
        offset_lo    = offset_ext[ADDR_W-1:0];
        s2_oob       = offset_hi_nz || (offset_lo > s2_limit);
        s2_sub       = (PPW_LOG2 == 0) ? '0 : s1_idx_q[SUB_W-1:0];
    end

    always_comb begin
        last_grant_d = accept ? grant_sel : last_grant_q;
        s1_valid_d   = s1_valid_q;
        s1_idx_d     = s1_idx_q;
        s1_layer_d   = s1_layer_q;
        sram_valid_d = sram_valid_q;
        sram_addr_d  = sram_addr_q;
        sub_idx_d    = sub_idx_q;
        layer_d      = layer_q;
        oob_d        = oob_q;
        if (s1_adv) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_idx_d   = req_idx_sel;
                s1_layer_d = grant_sel;
            end
        end
        if (s2_adv) begin
            sram_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sram_addr_d = s2_oob ? s2_base : s2_base + offset_lo;
                sub_idx_d   = s2_sub;
                layer_d     = s1_layer_q;
                oob_d       = s2_oob;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                base_q[k]  <= '0;
                limit_q[k] <= '1;
            end
            last_grant_q <= LAYER_W'(NUM_LAYERS - 1);
            s1_valid_q   <= 1'b0;
            s1_idx_q     <= '0;
            s1_layer_q   <= '0;
            sram_valid_q <= 1'b0;
            sram_addr_q  <= '0;
            sub_idx_q    <= '0;
            layer_q      <= '0;
            oob_q        <= 1'b0;
        end else begin
            base_q       <= base_d;
            limit_q      <= limit_d;
            last_grant_q <= last_grant_d;
            s1_valid_q   <= s1_valid_d;
            s1_idx_q     <= s1_idx_d;
            s1_layer_q   <= s1_layer_d;
            sram_valid_q <= sram_valid_d;
            sram_addr_q  <= sram_addr_d;
            sub_idx_q    <= sub_idx_d;
            layer_q      <= layer_d;
            oob_q        <= oob_d;
        end
    end

    assign bus.o_req_ready  = accept ? (NUM_LAYERS'(1) << grant_sel) : '0;
    assign bus.o_sram_valid = sram_valid_q;
    assign bus.o_sram_addr  = sram_addr_q;
    assign bus.o_sub_idx    = sub_idx_q;
    assign bus.o_layer      = layer_q;
    assign bus.o_oob        = oob_q;
endmodule

// File: tb/tb_sram_layer_addr_gen.sv
// Scoreboard bench for sram_layer_addr_gen: expectations are queued on accept
// and matched in order against every address the generator hands to the SRAM side.
module tb_sram_layer_addr_gen;
    localparam int NUM_LAYERS = 4;
    localparam int PIX_IDX_W  = 21;
    localparam int ADDR_W     = 20;
    localparam int PPW_LOG2   = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        sub;
        logic [1:0]        layer;
        logic              oob;
    } out_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sram_layer_addr_gen_if #(
        .NUM_LAYERS(NUM_LAYERS), .PIX_IDX_W(PIX_IDX_W), .ADDR_W(ADDR_W), .PPW_LOG2(PPW_LOG2)
    ) bus ();

    sram_layer_addr_gen #(
        .NUM_LAYERS(NUM_LAYERS), .PIX_IDX_W(PIX_IDX_W), .ADDR_W(ADDR_W), .PPW_LOG2(PPW_LOG2)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    out_t exp_q[$];
    out_t got_q[$];
    int   gnt_q[$];
    logic [ADDR_W-1:0] sh_base  [NUM_LAYERS];
    logic [ADDR_W-1:0] sh_limit [NUM_LAYERS];
    out_t samp;
    logic samp_valid, samp_ready;
    logic [NUM_LAYERS-1:0] acc_vec;

    function automatic out_t model(input int layer, input logic [PIX_IDX_W-1:0] idx);
        logic [31:0] off;
        out_t r;
        off     = 32'(idx) >> PPW_LOG2;
        r.oob   = ((off >> ADDR_W) != 0) || (off[ADDR_W-1:0] > sh_limit[layer]);
        r.addr  = r.oob ? sh_base[layer] : sh_base[layer] + off[ADDR_W-1:0];
        r.sub   = idx[1:0];
        r.layer = 2'(layer);
        return r;
    endfunction

    task automatic reset_shadow();
        for (int k = 0; k < NUM_LAYERS; k++) begin
            sh_base[k]  = '0;
            sh_limit[k] = '1;
        end
    endtask

    task automatic set_idx(input int layer, input logic [PIX_IDX_W-1:0] idx);
        bus.i_req_pix_idx[layer*PIX_IDX_W +: PIX_IDX_W] = idx;
    endtask

    // One clock: sample at the falling edge, log accepts/outputs, return 1ns after the rising edge.
    task automatic cycle();
        @(negedge clk);
        samp       = {bus.o_sram_addr, bus.o_sub_idx, bus.o_layer, bus.o_oob};
        samp_valid = bus.o_sram_valid;
        samp_ready = bus.i_sram_ready;
        acc_vec    = bus.i_req_valid & bus.o_req_ready;
        if (samp_valid && samp_ready) got_q.push_back(samp);
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (acc_vec[k]) begin
                exp_q.push_back(model(k, bus.i_req_pix_idx[k*PIX_IDX_W +: PIX_IDX_W]));
                gnt_q.push_back(k);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int layer, input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l);
        bus.i_cfg_we    = 1'b1;
        bus.i_cfg_layer = 2'(layer);
        bus.i_cfg_base  = b;
        bus.i_cfg_limit = l;
        if (layer < NUM_LAYERS) begin
            sh_base[layer]  = b;
            sh_limit[layer] = l;
        end
        cycle();
        bus.i_cfg_we = 1'b0;
    endtask

    task automatic send(input int layer, input logic [PIX_IDX_W-1:0] idx);
        int n = 0;
        set_idx(layer, idx);
        bus.i_req_valid = NUM_LAYERS'(1) << layer;
        do begin
            cycle();
            n++;
        end while (!acc_vec[layer] && n < 20);
        bus.i_req_valid = '0;
        checks++;
        if (!acc_vec[layer]) begin
            errors++;
            $display("[TB] FAIL accept_timeout layer %0d: accepted=0 required=1", layer);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        bus.i_req_valid  = '0;
        bus.i_sram_ready = 1'b1;
        while (exp_q.size() > got_q.size() && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (exp_q.size() > got_q.size()) begin
            errors++;
            $display("[TB] FAIL drain_timeout: outputs=%0d required=%0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        out_t g, e;
        rst_n            = 1'b0;
        bus.i_cfg_we     = 1'b0;
        bus.i_cfg_layer  = '0;
        bus.i_cfg_base   = '0;
        bus.i_cfg_limit  = '0;
        bus.i_sram_ready = 1'b1;
        bus.i_req_pix_idx = '0;
        reset_shadow();
        set_idx(0, 21'h000013);
        set_idx(1, 21'h000021);
        set_idx(2, 21'h000042);
        set_idx(3, 21'h000063);
        bus.i_req_valid = '1;
        repeat (3) cycle();
        checks++;
        if (bus.o_sram_valid !== 1'b0 || bus.o_req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_handshake: valid=%b ready=%b required valid=0 ready=0000",
                     bus.o_sram_valid, bus.o_req_ready);
        end
        checks++;
        if ({bus.o_sram_addr, bus.o_sub_idx, bus.o_layer, bus.o_oob} !== 25'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: addr=%h sub=%h layer=%h oob=%b required all zero",
                     bus.o_sram_addr, bus.o_sub_idx, bus.o_layer, bus.o_oob);
        end
        rst_n = 1'b1;
        cycle();
        checks++;
        if (acc_vec !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL first_grant: accepted=%b required=0001", acc_vec);
        end
        bus.i_req_valid = '0;
        checks++;
        if (bus.o_sram_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL latency_early: valid=%b required=0 after accept edge", bus.o_sram_valid);
        end
        cycle();
        checks++;
        if (bus.o_sram_valid !== 1'b1 || bus.o_sram_addr !== 20'h00004 || bus.o_sub_idx !== 2'd3 ||
            bus.o_layer !== 2'd0 || bus.o_oob !== 1'b0) begin
            errors++;
            $display("[TB] FAIL first_output: valid=%b addr=%h sub=%0d layer=%0d oob=%b required 1 00004 3 0 0",
                     bus.o_sram_valid, bus.o_sram_addr, bus.o_sub_idx, bus.o_layer, bus.o_oob);
        end
        drain(10);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL sb_reset: got=%h expected=%h", g, e);
            end
        end
    endtask

    task automatic test_base_offset();
        out_t g, e;
        logic [ADDR_W-1:0] want [2];
        logic [ADDR_W-1:0] bases [2];
        want[0]  = 20'h8FFFF;
        want[1]  = 20'h6FFFF;
        bases[0] = 20'h10000;
        bases[1] = 20'hF0000;
        for (int t = 0; t < 2; t++) begin
            cfg_write(2, bases[t], '1);
            send(2, 21'h1FFFFF);
            drain(10);
            g = (got_q.size() > 0) ? got_q[0] : '0;
            checks++;
            if (g.addr !== want[t] || g.oob !== 1'b0 || g.layer !== 2'd2) begin
                errors++;
                $display("[TB] FAIL base_offset_%0d: addr=%h oob=%b layer=%0d required %h 0 2",
                         t, g.addr, g.oob, g.layer, want[t]);
            end
            while (got_q.size() > 0 && exp_q.size() > 0) begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("[TB] FAIL sb_base: got=%h expected=%h", g, e);
                end
            end
        end
    endtask

    task automatic test_limit_oob();
        out_t g, e;
        cfg_write(1, 20'h00200, 20'h000FF);
        send(1, 21'h0003FC);
        send(1, 21'h000400);
        drain(10);
        g = (got_q.size() > 0) ? got_q[0] : '0;
        checks++;
        if (g.addr !== 20'h002FF || g.oob !== 1'b0) begin
            errors++;
            $display("[TB] FAIL limit_inside: addr=%h oob=%b required 002ff 0", g.addr, g.oob);
        end
        g = (got_q.size() > 1) ? got_q[1] : '0;
        checks++;
        if (g.addr !== 20'h00200 || g.oob !== 1'b1) begin
            errors++;
            $display("[TB] FAIL limit_oob: addr=%h oob=%b required 00200 1", g.addr, g.oob);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL sb_limit: got=%h expected=%h", g, e);
            end
        end
    endtask

    task automatic test_round_robin();
        out_t g, e;
        int all_order [8];
        int pair_order [4];
        int seen;
        all_order  = '{0, 1, 2, 3, 0, 1, 2, 3};
        pair_order = '{1, 3, 1, 3};
        send(3, 21'h000300);
        drain(10);
        gnt_q.delete();
        for (int k = 0; k < NUM_LAYERS; k++) set_idx(k, 21'(k * 16'h0104 + 5));
        bus.i_req_valid = 4'b1111;
        repeat (8) cycle();
        for (int i = 0; i < 8; i++) begin
            seen = (i < gnt_q.size()) ? gnt_q[i] : -1;
            checks++;
            if (seen !== all_order[i]) begin
                errors++;
                $display("[TB] FAIL rr_all[%0d]: granted=%0d required=%0d", i, seen, all_order[i]);
            end
        end
        gnt_q.delete();
        bus.i_req_valid = 4'b1010;
        repeat (4) cycle();
        for (int i = 0; i < 4; i++) begin
            seen = (i < gnt_q.size()) ? gnt_q[i] : -1;
            checks++;
            if (seen !== pair_order[i]) begin
                errors++;
                $display("[TB] FAIL rr_pair[%0d]: granted=%0d required=%0d", i, seen, pair_order[i]);
            end
        end
        drain(10);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL sb_rr: got=%h expected=%h", g, e);
            end
        end
    endtask

    task automatic test_back_pressure();
        out_t g, e, held;
        logic [NUM_LAYERS-1:0] pend;
        logic stall_prev;
        int tag_next, n;
        pend       = '0;
        stall_prev = 1'b0;
        held       = '0;
        tag_next   = 0;
        n          = 0;
        exp_q.delete();
        got_q.delete();
        while ((tag_next < 100 || pend != '0 || exp_q.size() > got_q.size()) && n < 3000) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                if (!pend[k] && tag_next < 100 && $urandom_range(0, 1) == 1) begin
                    pend[k] = 1'b1;
                    set_idx(k, 21'((tag_next << 2) | k));
                    tag_next++;
                end
            end
            bus.i_req_valid  = pend;
            bus.i_sram_ready = ($urandom_range(0, 1) == 1);
            cycle();
            n++;
            if (stall_prev) begin
                checks++;
                if (samp_valid !== 1'b1 || samp !== held) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: valid=%b out=%h required 1 %h", samp_valid, samp, held);
                end
            end
            pend       = pend & ~acc_vec;
            stall_prev = samp_valid && !samp_ready;
            held       = samp;
        end
        bus.i_req_valid  = '0;
        bus.i_sram_ready = 1'b1;
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("[TB] FAIL bp_timeout: cycles=%0d required<3000", n);
        end
        checks++;
        if (exp_q.size() !== 100 || got_q.size() !== 100) begin
            errors++;
            $display("[TB] FAIL bp_count: accepted=%0d delivered=%0d required 100 100", exp_q.size(), got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL sb_bp: got=%h expected=%h", g, e);
            end
        end
    endtask

    task automatic test_cfg_race();
        out_t g, e;
        bus.i_sram_ready = 1'b1;
        send(0, 21'h000040);
        cfg_write(0, 20'h00100, '1);
        send(0, 21'h000040);
        drain(10);
        g = (got_q.size() > 0) ? got_q[0] : '0;
        checks++;
        if (g.addr !== 20'h00010) begin
            errors++;
            $display("[TB] FAIL race_old_base: addr=%h required 00010", g.addr);
        end
        g = (got_q.size() > 1) ? got_q[1] : '0;
        checks++;
        if (g.addr !== 20'h00110) begin
            errors++;
            $display("[TB] FAIL race_new_base: addr=%h required 00110", g.addr);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL sb_race: got=%h expected=%h", g, e);
            end
        end
    endtask

    task automatic test_mid_reset();
        out_t g, e;
        bus.i_sram_ready = 1'b0;
        send(2, 21'h000080);
        send(3, 21'h000090);
        set_idx(0, 21'h000040);
        bus.i_req_valid = 4'b0001;
        #1;
        checks++;
        if (bus.o_sram_valid !== 1'b1 || bus.o_req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL full_stall: valid=%b ready=%b required 1 0000", bus.o_sram_valid, bus.o_req_ready);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_sram_valid !== 1'b0 || bus.o_req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL async_reset: valid=%b ready=%b required 0 0000", bus.o_sram_valid, bus.o_req_ready);
        end
        exp_q.delete();
        got_q.delete();
        reset_shadow();
        bus.i_req_valid = '0;
        @(posedge clk);
        #1;
        rst_n            = 1'b1;
        bus.i_sram_ready = 1'b1;
        send(0, 21'h000040);
        drain(10);
        g = (got_q.size() > 0) ? got_q[0] : '0;
        checks++;
        if (g.addr !== 20'h00010) begin
            errors++;
            $display("[TB] FAIL reset_base_default: addr=%h required 00010", g.addr);
        end
        checks++;
        if (got_q.size() !== 1) begin
            errors++;
            $display("[TB] FAIL reset_flush: outputs=%0d required 1", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL sb_midreset: got=%h expected=%h", g, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_base_offset();
        test_limit_oob();
        test_round_robin();
        test_back_pressure();
        test_cfg_race();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end
endmodule

// File: doc/sram_layer_addr_gen.md
# sram_layer_addr_gen

Multi-layer SRAM address generator for the sprite/background pixel path. Up to NUM_LAYERS object layers each present a pixel index. A round-robin arbiter picks one per cycle, and a registered two-stage pipeline turns it into a packed SRAM word address: per-layer programmable base plus the index divided by pixels-per-word. The block also reports the sub-word pixel slot, a layer tag and an out-of-bounds flag, and honours back-pressure from the SRAM controller.

## Interface
Parameters:
- NUM_LAYERS, 4, number of requesting layers (≥1)
- PIX_IDX_W, 21, pixel index width
- ADDR_W, 20, SRAM word address width
- PPW_LOG2, 2, log2(pixels per SRAM word); 0 allowed

Ports (one clock; reset is asynchronous and active-low):
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_cfg_we  in  1  config write strobe
- i_cfg_layer  in  max(1,$clog2(NUM_LAYERS))  layer being configured
- i_cfg_base  in  ADDR_W  layer base word address
- i_cfg_limit  in  ADDR_W  last valid word offset of layer (inclusive)
- i_req_valid  in  NUM_LAYERS  per-layer request valid
- i_req_pix_idx  in  NUM_LAYERS*PIX_IDX_W  packed indices; layer k at [k*PIX_IDX_W +: PIX_IDX_W]
- o_req_ready  out  NUM_LAYERS  one-hot grant/accept
- o_sram_valid  out  1  output address valid
- i_sram_ready  in  1  SRAM controller accepts the output
- o_sram_addr  out  ADDR_W  word address
- o_sub_idx  out  max(1,PPW_LOG2)  pixel slot within word (idx[PPW_LOG2-1:0]; 0 if PPW_LOG2=0)
- o_layer  out  max(1,$clog2(NUM_LAYERS))  layer tag of the output
- o_oob  out  1  offset exceeded limit; address forced to base

## Operation
- Handshakes are valid/ready. A transfer occurs when valid & ready are both high on a rising edge.
- Request valid must be held with a stable index until ready. The arbiter may grant a different layer meanwhile.
- Arbiter: round-robin. Search starts at the layer after last_grant. last_grant updates only on an accepted request. Reset last_grant = NUM_LAYERS-1, so layer 0 wins first.
- o_req_ready is one-hot or zero. It is zero whenever stage 1 cannot advance.
- Stage 1 (S1) registers the granted index and layer.
- Stage 2 (S2) computes from S1:
  - offset = idx >> PPW_LOG2.
  - oob = (upper offset bits above ADDR_W are nonzero) OR (offset[ADDR_W-1:0] > limit[layer]).
  - addr = oob ? base[layer] : (base[layer] + offset) mod 2^ADDR_W. Wrap is silent.
  - All four results are registered into the outputs.
- Advance rules:
  - s2_adv = !o_sram_valid | i_sram_ready.
  - s1_adv = !s1_valid | s2_adv.
  - Grant is allowed only when s1_adv.
- Stalled outputs hold every output bit stable.
- Config registers: base and limit, one pair per layer.
  - Written on i_cfg_we. A write to a layer index ≥ NUM_LAYERS is ignored.
  - S2 samples base/limit combinationally in its compute cycle. A write in that same cycle is not seen: the old value is used and the new value applies from the next cycle.
- Reset values:
  - o_sram_valid=0, o_req_ready=0, o_sram_addr=0, o_sub_idx=0, o_layer=0, o_oob=0.
  - S1 empty; base[*]=0; limit[*]=all ones.
- Reset asserted mid-operation empties both stages immediately and restores the config defaults. In-flight requests are lost.

## Timing
- Latency: request accepted on edge N → o_sram_valid high after edge N+2 (two registers). This holds with no stall.
- Throughput: 1 address/cycle sustained while i_sram_ready=1.
- o_req_ready is combinational from i_req_valid, last_grant and pipeline state. There is no combinational path from i_req_pix_idx to any output.
- i_sram_ready low while full: S2 holds. S1 holds if occupied. Grants stop one cycle later at most, with no lost or duplicated transfer.
- Empty pipeline with i_sram_ready=0: S2 still accepts one entry, and S1 accepts one entry.

## Test plan
- Reset defaults: after reset, all layers request, layer 0 idx=0x000013 → o_sram_addr=0x00004, o_sub_idx=3, o_layer=0, o_oob=0, valid on the 2nd edge after accept.
- Base offset: cfg layer2 base=0x10000. Layer2 idx=0x1FFFFF → offset 0x7FFFF, addr=0x8FFFF. With base=0xF0000 it wraps: addr=0x6FFFF, o_oob=0.
- Limit/OOB: layer1 base=0x200, limit=0x0FF. idx=0x3FC → addr=0x2FF, oob=0. idx=0x400 → addr=0x200, oob=1.
- Round-robin fairness: all 4 layers held valid for 8 cycles, i_sram_ready=1 → grant order 0,1,2,3,0,1,2,3. Then only layers 1 and 3 valid → 1,3,1,3.
- Back-pressure: random i_sram_ready (50%) with 100 tagged requests → the output sequence equals the accept sequence in order, with no drops or duplicates. Outputs are stable during every stall.
- Config race and mid-op reset: cfg write to layer0 base=0x100 in the same cycle S2 computes a layer0 request → old base used, the next request uses 0x100. Assert i_rst_n low with both stages full → o_sram_valid=0 immediately and base[0] reads back as 0 on the next request.
